// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and forward-select helpers
//
// Purpose: ALU opcode constants, the operand forward-select enum and the
//          forwarding priority function used by the ID/EX stage.
// Ports:   none (package).
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_EQ  = 4'b1000;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // x0 is hardwired zero, so a pending write to it must never be forwarded.
  // The younger EX/MEM result wins over MEM/WB.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] rs,
    input logic       exmem_we,
    input logic [4:0] exmem_rd,
    input logic       memwb_we,
    input logic [4:0] memwb_rd
  );
    if (rs == 5'd0)                   return FWD_RF;
    if (exmem_we && exmem_rd == rs)   return FWD_EXMEM;
    if (memwb_we && memwb_rd == rs)   return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/idex_skid_buf.sv
// rtl/idex_skid_buf.sv - two-entry valid/ready buffer (main + skid register)
//
// Purpose: registers one payload per accepted transfer with latency 1 and
//          full throughput; the skid entry absorbs the one extra word that
//          can arrive while main is stalled, so in_ready is a pure register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               clears both entries and drops same-cycle input
//   in_valid/in_ready   upstream handshake (in_ready = !skid_valid)
//   in_data             upstream payload
//   out_valid/out_ready downstream handshake
//   out_data            downstream payload (main register)
module idex_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      // Main is free this edge: the skid word is older than anything
      // upstream, and while skid is occupied in_ready is low anyway.
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_valid;
        if (in_valid) main_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/idex_alu_stage.sv
// rtl/idex_alu_stage.sv - ID/EX pipeline stage feeding the ALU
//
// Purpose: resolves operand forwarding at acceptance, selects operand B,
//          flags undefined opcodes and registers the result through a
//          two-entry skid buffer.
// Config:  IDEX_FWD_EN - when defined, EX/MEM and MEM/WB forwarding is
//          enabled; otherwise register-file data is used unconditionally.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               decode handshake
//   in_rs1_addr/in_rs2_addr         source register indices
//   in_rs1_data/in_rs2_data         register-file read data
//   in_imm, in_alusrc               immediate and operand-B select
//   in_operation                    ALU opcode
//   exmem_*/memwb_*                 forwarding sources
//   flush                           discard held and incoming instructions
//   out_valid/out_ready             ALU handshake
//   SrcA, SrcB, Operation           ALU operands and opcode
//   out_store_data                  forwarded rs2 value
//   out_illegal_op                  Operation is not a defined code
module idex_alu_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rs1_addr,
  input  logic [4:0]               in_rs2_addr,
  input  logic [DATA_WIDTH-1:0]    in_rs1_data,
  input  logic [DATA_WIDTH-1:0]    in_rs2_data,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic                     in_alusrc,
  input  logic [OPCODE_LENGTH-1:0] in_operation,
  input  logic                     exmem_regwrite,
  input  logic [4:0]               exmem_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic                     memwb_regwrite,
  input  logic [4:0]               memwb_rd,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    out_store_data,
  output logic                     out_illegal_op
);

  import alu_pkg::*;

  localparam int PW = 3 * DATA_WIDTH + OPCODE_LENGTH + 1;

  fwd_sel_e              sel_a;
  fwd_sel_e              sel_b;
  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  illegal;
  logic [PW-1:0]         in_payload;
  logic [PW-1:0]         out_payload;

`ifdef IDEX_FWD_EN
  assign sel_a = fwd_select(in_rs1_addr, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
  assign sel_b = fwd_select(in_rs2_addr, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
`else
  logic unused_fwd;
  assign unused_fwd = ^{in_rs1_addr, in_rs2_addr, exmem_regwrite, exmem_rd,
                        memwb_regwrite, memwb_rd};
  assign sel_a = FWD_RF;
  assign sel_b = FWD_RF;
`endif

  always_comb begin
    fwd_rs1 = in_rs1_data;
    case (sel_a)
      FWD_EXMEM: fwd_rs1 = exmem_result;
      FWD_MEMWB: fwd_rs1 = memwb_result;
      default:   fwd_rs1 = in_rs1_data;
    endcase
  end

  always_comb begin
    fwd_rs2 = in_rs2_data;
    case (sel_b)
      FWD_EXMEM: fwd_rs2 = exmem_result;
      FWD_MEMWB: fwd_rs2 = memwb_result;
      default:   fwd_rs2 = in_rs2_data;
    endcase
  end

  assign src_b = in_alusrc ? in_imm : fwd_rs2;

  always_comb begin
    illegal = 1'b1;
    case (in_operation)
      OPCODE_LENGTH'(ALU_AND), OPCODE_LENGTH'(ALU_OR),  OPCODE_LENGTH'(ALU_ADD),
      OPCODE_LENGTH'(ALU_XOR), OPCODE_LENGTH'(ALU_SUB), OPCODE_LENGTH'(ALU_SLT),
      OPCODE_LENGTH'(ALU_EQ):  illegal = 1'b0;
      default:                 illegal = 1'b1;
    endcase
  end

  assign in_payload = {fwd_rs1, src_b, in_operation, fwd_rs2, illegal};

  // flush is applied inside the buffer so it also masks the same-cycle accept
  idex_skid_buf #(
    .WIDTH (PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {SrcA, SrcB, Operation, out_store_data, out_illegal_op} = out_payload;

endmodule

// File: tb/tb_idex_alu_stage.sv
// tb/tb_idex_alu_stage.sv - directed self-checking bench for idex_alu_stage
module tb_idex_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_alusrc;
  logic [3:0]  in_operation;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] SrcA, SrcB, out_store_data;
  logic [3:0]  Operation;
  logic        out_illegal_op;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_a, exp_b;

  idex_alu_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1_addr    (in_rs1_addr),
    .in_rs2_addr    (in_rs2_addr),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .in_alusrc      (in_alusrc),
    .in_operation   (in_operation),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .SrcA           (SrcA),
    .SrcB           (SrcB),
    .Operation      (Operation),
    .out_store_data (out_store_data),
    .out_illegal_op (out_illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] r2, input logic [31:0] d2);
    in_valid     = 1'b1;
    in_operation = op;
    in_rs1_addr  = r1;
    in_rs1_data  = d1;
    in_rs2_addr  = r2;
    in_rs2_data  = d2;
    in_alusrc    = 1'b0;
    in_imm       = 32'h0;
  endtask

  task automatic clr_fwd();
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in(4'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    in_valid = 1'b0;
    clr_fwd();

    // reset state
    repeat (2) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_srca", SrcA, 0);
    chk("rst_op", Operation, 0);
    chk("rst_illegal", out_illegal_op, 0);
    rst_n = 1'b1;

    // back-to-back, first accept on first edge after reset release
    out_ready = 1'b1;
    set_in(4'b0010, 5'd1, 32'd5, 5'd2, 32'd7);
    tick();
    chk("bb1_valid", out_valid, 1);
    chk("bb1_srca", SrcA, 5);
    chk("bb1_srcb", SrcB, 7);
    chk("bb1_op", Operation, 4'b0010);
    chk("bb1_illegal", out_illegal_op, 0);
    set_in(4'b0110, 5'd3, 32'd10, 5'd4, 32'd3);
    tick();
    chk("bb2_valid", out_valid, 1);
    chk("bb2_srca", SrcA, 10);
    chk("bb2_op", Operation, 4'b0110);
    in_valid = 1'b0;
    tick();
    chk("bb_drained", out_valid, 0);

    // EX/MEM priority over MEM/WB
`ifdef IDEX_FWD_EN
    exp_a = 32'h64;
`else
    exp_a = 32'd5;
`endif
    exmem_regwrite = 1'b1; exmem_rd = 5'd1; exmem_result = 32'h64;
    memwb_regwrite = 1'b1; memwb_rd = 5'd1; memwb_result = 32'h10;
    set_in(4'b0010, 5'd1, 32'd5, 5'd2, 32'd7);
    tick();
    chk("fwd_exmem_srca", SrcA, exp_a);
    chk("fwd_exmem_srcb", SrcB, 7);

    // x0 guard on rs1, MEM/WB forward on rs2
`ifdef IDEX_FWD_EN
    exp_b = 32'h10;
`else
    exp_b = 32'd7;
`endif
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h55;
    memwb_regwrite = 1'b1; memwb_rd = 5'd2; memwb_result = 32'h10;
    set_in(4'b0010, 5'd0, 32'd0, 5'd2, 32'd7);
    tick();
    chk("x0_srca", SrcA, 0);
    chk("memwb_srcb", SrcB, exp_b);
    clr_fwd();
    in_valid = 1'b0;
    tick();

    // backpressure: I1 to main, I2 to skid, I3 held off
    out_ready = 1'b0;
    set_in(4'b0000, 5'd1, 32'h11, 5'd2, 32'h22);
    tick();
    chk("bp_ready1", in_ready, 1);
    set_in(4'b0001, 5'd3, 32'h33, 5'd4, 32'h44);
    tick();
    chk("bp_ready2", in_ready, 0);
    chk("bp_srca1", SrcA, 32'h11);
    set_in(4'b0011, 5'd5, 32'h55, 5'd6, 32'h66);
    tick();
    chk("bp_hold_srca", SrcA, 32'h11);
    chk("bp_hold_op", Operation, 4'b0000);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_i2_srca", SrcA, 32'h33);
    chk("bp_i2_op", Operation, 4'b0001);
    chk("bp_ready3", in_ready, 1);
    tick();
    chk("bp_i3_srca", SrcA, 32'h55);
    chk("bp_i3_op", Operation, 4'b0011);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", out_valid, 0);

    // flush with both entries full and input offered
    out_ready = 1'b0;
    set_in(4'b0010, 5'd1, 32'h1, 5'd2, 32'h2);
    tick();
    set_in(4'b0010, 5'd1, 32'h3, 5'd2, 32'h4);
    tick();
    chk("fl_full", in_ready, 0);
    flush = 1'b1;
    tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    // flush also drops an input that would otherwise be accepted
    tick();
    chk("fl_drop", out_valid, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    // alusrc with forwarded store data
`ifdef IDEX_FWD_EN
    exp_b = 32'd9;
`else
    exp_b = 32'h77;
`endif
    exmem_regwrite = 1'b1; exmem_rd = 5'd2; exmem_result = 32'd9;
    set_in(4'b0010, 5'd1, 32'd1, 5'd2, 32'h77);
    in_alusrc = 1'b1; in_imm = 32'hFFFF_FFFC;
    tick();
    chk("imm_srcb", SrcB, 32'hFFFF_FFFC);
    chk("imm_store", out_store_data, exp_b);
    clr_fwd();

    // asynchronous reset mid-stall
    out_ready = 1'b0;
    set_in(4'b0011, 5'd1, 32'hAA, 5'd2, 32'hBB);
    tick();
    in_valid = 1'b0;
    chk("st_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_srca", SrcA, 0);
    chk("ar_srcb", SrcB, 0);
    chk("ar_op", Operation, 0);
    chk("ar_store", out_store_data, 0);
    chk("ar_ready", in_ready, 1);

    // release and accept on the very next edge; opcode legality
    out_ready = 1'b1;
    set_in(4'b0101, 5'd1, 32'd1, 5'd2, 32'd2);
    rst_n = 1'b1;
    tick();
    chk("il_valid", out_valid, 1);
    chk("il_0101", out_illegal_op, 1);
    chk("il_op", Operation, 4'b0101);
    set_in(4'b1000, 5'd1, 32'd1, 5'd2, 32'd2);
    tick();
    chk("il_1000", out_illegal_op, 0);
    set_in(4'b1111, 5'd1, 32'd1, 5'd2, 32'd2);
    tick();
    chk("il_1111", out_illegal_op, 1);
    set_in(4'b0111, 5'd1, 32'd1, 5'd2, 32'd2);
    tick();
    chk("il_0111", out_illegal_op, 0);
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/idex_alu_stage.md
IDEX_ALU_STAGE -- requirements
Module: idex_alu_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of operands, results and immediates.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 4: width of the ALU Operation code.
REQ-003 SHALL have ports:
- clk  in  1  single clock, rising edge; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have decode-side ports:
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage can accept.
- in_rs1_addr, in_rs2_addr  in  5  source register indices.
- in_rs1_data, in_rs2_data  in  DATA_WIDTH  register-file read data.
- in_imm  in  DATA_WIDTH  sign-extended immediate.
- in_alusrc  in  1  1 selects in_imm as operand B.
- in_operation  in  OPCODE_LENGTH  ALU operation code.
REQ-005 SHALL have forwarding ports:
- exmem_regwrite  in  1  EX/MEM writes rd.
- exmem_rd  in  5  EX/MEM destination.
- exmem_result  in  DATA_WIDTH  EX/MEM value.
- memwb_regwrite, memwb_rd, memwb_result  in  1/5/DATA_WIDTH  same, for MEM/WB.
REQ-006 SHALL have control port flush  in  1  discards all held and incoming instructions.
REQ-007 SHALL have ALU-side ports:
- out_valid  out  1  SrcA/SrcB/Operation are valid.
- out_ready  in  1  ALU consumer accepts.
- SrcA, SrcB  out  DATA_WIDTH  ALU operands.
- Operation  out  OPCODE_LENGTH  ALU operation.
- out_store_data  out  DATA_WIDTH  forwarded rs2 value.
- out_illegal_op  out  1  Operation is not a defined code.

Function
REQ-008 SHALL accept on cycles where in_valid && in_ready && !flush; out_valid SHALL rise on the next edge (latency 1).
REQ-009 SHALL transfer on cycles where out_valid && out_ready; sustained throughput SHALL be 1 instruction/cycle while out_ready=1.
REQ-010 SHALL hold a main register and one skid register:
- Accepting while main is full and not draining loads skid.
- in_ready SHALL equal !skid_valid, registered, with no combinational path from out_ready.
REQ-011 SHALL move skid to main on the edge where main drains; ordering SHALL be strict FIFO.
REQ-012 SHALL hold SrcA, SrcB, Operation, out_store_data and out_illegal_op stable while out_valid && !out_ready.
REQ-013 SHALL resolve forwarding at acceptance, per source (rs1, rs2):
- EX/MEM match (regwrite && rd==rs && rd!=0) takes priority.
- Otherwise a MEM/WB match.
- Otherwise register-file data.
REQ-014 SHALL never forward for rs index 0; operand reads in_rsX_data unchanged.
REQ-015 SHALL set SrcB = in_imm when in_alusrc=1, else forwarded rs2; out_store_data SHALL always be forwarded rs2.
REQ-016 SHALL set out_illegal_op=1 for any in_operation outside {0000,0001,0010,0011,0110,0111,1000}; Operation SHALL pass unchanged.
REQ-017 SHALL, on flush, clear main and skid valid at the next edge and drop any same-cycle input (flush wins over accept and transfer).

Reset
REQ-018 SHALL, while rst_n=0, force out_valid=0, skid empty, in_ready=1, and SrcA, SrcB, Operation, out_store_data, out_illegal_op all 0, independent of clk.
REQ-019 SHALL, on reset assertion mid-transfer, discard all held instructions; the first accept SHALL be possible on the first edge after rst_n rises.

Configuration
REQ-020 SHALL implement forwarding (REQ-013) only when IDEX_FWD_EN is defined.
REQ-021 SHALL, without IDEX_FWD_EN, use register-file data unconditionally; forwarding inputs remain ports but SHALL be ignored.

Structure
REQ-022 SHALL take ALU operation codes (AND, OR, ADD, XOR, SUB, SLT, EQ) and the forward-select enum (FWD_RF, FWD_EXMEM, FWD_MEMWB) from shared package alu_pkg.
REQ-023 SHALL instantiate one sub-module, idex_skid_buf, holding the two-entry valid/ready buffer; forwarding and operand muxing stay in the top.

Verification
REQ-024 SHALL cover these directed scenarios:
- Back-to-back: ADD, rs1=x1 (data 5), rs2=x2 (data 7), out_ready=1 -> next cycle SrcA=5, SrcB=7, Operation=0010, out_valid=1.
- EX/MEM forward: exmem rd=x1, result 0x64, plus memwb rd=x1, result 0x10 -> SrcA=0x64.
- x0 guard: exmem rd=0, regwrite=1, rs1=x0, rf data 0 -> SrcA=0.
- Backpressure: out_ready=0 for 3 cycles, two instructions offered -> second goes to skid, in_ready=0, third held; after out_ready=1 outputs appear in order.
- Flush and alusrc: flush with both entries full and in_valid=1 -> out_valid=0 next cycle; in_alusrc=1, imm=0xFFFFFFFC, rs2 forwarded 9 -> SrcB=0xFFFFFFFC, out_store_data=9.
- Async reset: rst_n low mid-stall -> all outputs 0 immediately; Operation 0101 after reset -> out_illegal_op=1.
